// File: rtl/i2s_mic_pkg.sv
// Shared defaults and state encoding for the I2S microphone receiver.
package i2s_mic_pkg;
  localparam int DATA_W_DEF = 24;
  localparam int SLOT_W_DEF = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SYNC = 2'd1,
    RUN  = 2'd2
  } state_t;
endpackage

// File: rtl/i2s_mic_rx_if.sv
// Bundle of the serial microphone lines and the recovered PCM stream.
interface i2s_mic_rx_if
  import i2s_mic_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) ();
  logic              sck;
  logic              ws;
  logic              sd;
  logic [DATA_W-1:0] pcm_data;
  logic              pcm_chan;
  logic              pcm_valid;
  logic              frame_err;

  modport master (input sck, ws, sd, output pcm_data, pcm_chan, pcm_valid, frame_err);
  modport slave  (output sck, ws, sd, input pcm_data, pcm_chan, pcm_valid, frame_err);
endinterface

// File: rtl/sync_edge_det.sv
// Two-flop synchronizer followed by a registered rising-edge pulse.
module sync_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise
);
  logic [1:0] sync_reg;
  logic       prev_reg;
  logic       rise_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_reg <= 2'b00;
      prev_reg <= 1'b0;
      rise_reg <= 1'b0;
    end else begin
      sync_reg <= {sync_reg[0], din};
      prev_reg <= sync_reg[1];
      rise_reg <= sync_reg[1] & ~prev_reg;
    end
  end

  assign rise = rise_reg;
endmodule

// File: rtl/i2s_mic_rx.sv
// I2S microphone receiver: oversamples SCK/WS/SD in the clk domain and
// emits one PCM word per slot, flagging slots that are too short or too long.
module i2s_mic_rx
  import i2s_mic_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int SLOT_W = SLOT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              mic_sck,
  input  logic              mic_ws,
  input  logic              mic_sd,
  output logic [DATA_W-1:0] pcm_data,
  output logic              pcm_chan,
  output logic              pcm_valid,
  output logic              frame_err
);
  localparam int CNT_W = $clog2(SLOT_W + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] CNT_DATA = CNT_W'(DATA_W);
  localparam logic [CNT_W-1:0] CNT_SLOT = CNT_W'(SLOT_W);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic              sck_rise;
  logic [1:0]        ws_sync_reg, sd_sync_reg;
  logic              ws_s, sd_s;
  state_t            state_reg, state_next;
  logic [CNT_W-1:0]  bit_cnt_reg, bit_cnt_next;
  logic [DATA_W-1:0] shift_reg, shift_next, shifted;
  logic              ws_prev_reg, ws_prev_next;
  logic              primed_reg, primed_next;
  logic              chan_reg, chan_next;
  logic [DATA_W-1:0] pcm_data_reg, pcm_data_next;
  logic              pcm_chan_reg, pcm_chan_next;
  logic              pcm_valid_reg, pcm_valid_next;
  logic              frame_err_reg, frame_err_next;

  sync_edge_det u_sck_sync (
    .clk  (clk),
    .rst  (rst),
    .din  (mic_sck),
    .rise (sck_rise)
  );

  assign ws_s    = ws_sync_reg[1];
  assign sd_s    = sd_sync_reg[1];
  assign shifted = {shift_reg[DATA_W-2:0], sd_s};

  always_comb begin
    state_next     = state_reg;
    bit_cnt_next   = bit_cnt_reg;
    shift_next     = shift_reg;
    ws_prev_next   = ws_prev_reg;
    primed_next    = primed_reg;
    chan_next      = chan_reg;
    pcm_data_next  = pcm_data_reg;
    pcm_chan_next  = pcm_chan_reg;
    pcm_valid_next = 1'b0;
    frame_err_next = 1'b0;
    case (state_reg)
      IDLE: begin
        bit_cnt_next = '0;
        primed_next  = 1'b0;
        if (en) state_next = SYNC;
      end
      SYNC: begin
        // The first rise after IDLE only records WS; an edge needs two samples.
        if (sck_rise) begin
          ws_prev_next = ws_s;
          primed_next  = 1'b1;
          if (primed_reg && (ws_s != ws_prev_reg)) begin
            state_next   = RUN;
            bit_cnt_next = '0;
            chan_next    = ws_s;
            shift_next   = '0;
          end
        end
      end
      RUN: begin
        if (sck_rise) begin
          ws_prev_next = ws_s;
          if (ws_s != ws_prev_reg) begin
            frame_err_next = (bit_cnt_reg < CNT_DATA);
            bit_cnt_next   = '0;
            chan_next      = ws_s;
            shift_next     = '0;
          end else if (bit_cnt_reg == CNT_SLOT) begin
            frame_err_next = 1'b1;
            state_next     = SYNC;
            bit_cnt_next   = '0;
          end else begin
            bit_cnt_next = bit_cnt_reg + CNT_ONE;
            if (bit_cnt_reg < CNT_DATA) shift_next = shifted;
            if (bit_cnt_reg == CNT_LAST) begin
              pcm_data_next  = shifted;
              pcm_chan_next  = chan_reg;
              pcm_valid_next = 1'b1;
            end
          end
        end
      end
      default: state_next = IDLE;
    endcase
    if (!en) begin
      state_next     = IDLE;
      bit_cnt_next   = '0;
      shift_next     = '0;
      pcm_valid_next = 1'b0;
      frame_err_next = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ws_sync_reg   <= 2'b00;
      sd_sync_reg   <= 2'b00;
      state_reg     <= IDLE;
      bit_cnt_reg   <= '0;
      shift_reg     <= '0;
      ws_prev_reg   <= 1'b0;
      primed_reg    <= 1'b0;
      chan_reg      <= 1'b0;
      pcm_data_reg  <= '0;
      pcm_chan_reg  <= 1'b0;
      pcm_valid_reg <= 1'b0;
      frame_err_reg <= 1'b0;
    end else begin
      ws_sync_reg   <= {ws_sync_reg[0], mic_ws};
      sd_sync_reg   <= {sd_sync_reg[0], mic_sd};
      state_reg     <= state_next;
      bit_cnt_reg   <= bit_cnt_next;
      shift_reg     <= shift_next;
      ws_prev_reg   <= ws_prev_next;
      primed_reg    <= primed_next;
      chan_reg      <= chan_next;
      pcm_data_reg  <= pcm_data_next;
      pcm_chan_reg  <= pcm_chan_next;
      pcm_valid_reg <= pcm_valid_next;
      frame_err_reg <= frame_err_next;
    end
  end

  assign pcm_data  = pcm_data_reg;
  assign pcm_chan  = pcm_chan_reg;
  assign pcm_valid = pcm_valid_reg;
  assign frame_err = frame_err_reg;
endmodule

// File: tb/tb_i2s_mic_rx.sv
// Directed/randomized bench: drives I2S slots and compares the PCM and error
// pulses (value, channel and exact clk cycle) against a bit-level slot model.
`timescale 1ns/1ps
module tb_i2s_mic_rx;
  localparam int DW = 24;
  localparam int SW = 32;

  logic clk = 1'b0;
  logic rst;
  logic en;

  i2s_mic_rx_if #(.DATA_W(DW)) bus ();

  i2s_mic_rx #(.DATA_W(DW), .SLOT_W(SW)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .mic_sck   (bus.sck),
    .mic_ws    (bus.ws),
    .mic_sd    (bus.sd),
    .pcm_data  (bus.pcm_data),
    .pcm_chan  (bus.pcm_chan),
    .pcm_valid (bus.pcm_valid),
    .frame_err (bus.frame_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          err;
    bit          chan;
    logic [DW-1:0] data;
    int          cyc;
  } ev_t;

  ev_t exp_q[$];
  ev_t act_q[$];
  int  errors = 0;
  int  checks = 0;
  int  cyc = 0;
  int  half = 10;

  bit          m_run, m_primed, m_prev, m_chan;
  int          m_n;
  logic [DW-1:0] m_word, m_last;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  always @(negedge clk) begin
    if (bus.pcm_valid || bus.frame_err) begin
      chk("valid_err_exclusive", 64'(bus.pcm_valid & bus.frame_err), 64'd0);
      act_q.push_back('{err: bus.frame_err, chan: bus.pcm_chan, data: bus.pcm_data, cyc: cyc});
      $display("event err=%0d chan=%0d data=%06h cyc=%0d", bus.frame_err, bus.pcm_chan, bus.pcm_data, cyc);
    end
  end

  // Reference: a slot opens on a WS change, then the next DW rises are data
  // MSB-first; more than SW rises without a change is an overlong slot.
  // The raw rise is registered on the next posedge (cyc+1); results are due 3 later.
  task model_rise(input bit ws, input bit sd);
    if (!m_run) begin
      if (m_primed && ws != m_prev) begin
        m_run  = 1'b1;
        m_n    = 0;
        m_chan = ws;
      end
      m_primed = 1'b1;
    end else if (ws != m_prev) begin
      if (m_n < DW) exp_q.push_back('{err: 1'b1, chan: 1'b0, data: '0, cyc: cyc + 4});
      m_n    = 0;
      m_chan = ws;
    end else begin
      m_n++;
      if (m_n <= DW) m_word = {m_word[DW-2:0], sd};
      if (m_n == DW) begin
        exp_q.push_back('{err: 1'b0, chan: m_chan, data: m_word, cyc: cyc + 4});
        m_last = m_word;
      end
      if (m_n > SW) begin
        exp_q.push_back('{err: 1'b1, chan: 1'b0, data: '0, cyc: cyc + 4});
        m_run = 1'b0;
      end
    end
    m_prev = ws;
  endtask

  task model_reset();
    m_run    = 1'b0;
    m_primed = 1'b0;
    m_n      = 0;
  endtask

  task automatic rise_bit(input bit ws, input bit sd);
    bus.sck = 1'b0;
    bus.ws  = ws;
    bus.sd  = sd;
    repeat (half) @(negedge clk);
    bus.sck = 1'b1;
    model_rise(ws, sd);
    repeat (half) @(negedge clk);
  endtask

  // n rises: first carries the WS value (edge rise), then data MSB first, then padding.
  task automatic send_slot(input bit ch, input logic [DW-1:0] w, input int n);
    for (int i = 0; i < n; i++) begin
      bit b;
      b = (i >= 1 && i <= DW) ? w[DW-i] : 1'($urandom);
      rise_bit(ch, b);
    end
  endtask

  task automatic gap();
    bus.sck = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  task automatic check_events(input string tag);
    ev_t e, a;
    chk({tag, "_count"}, 64'(act_q.size()), 64'(exp_q.size()));
    while (exp_q.size() > 0 && act_q.size() > 0) begin
      e = exp_q.pop_front();
      a = act_q.pop_front();
      chk({tag, "_kind"}, 64'(a.err), 64'(e.err));
      chk({tag, "_cycle"}, 64'(a.cyc), 64'(e.cyc));
      if (!e.err && !a.err) begin
        chk({tag, "_chan"}, 64'(a.chan), 64'(e.chan));
        chk({tag, "_data"}, 64'(a.data), 64'(e.data));
      end
    end
    exp_q.delete();
    act_q.delete();
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_pcm_data"}, 64'(bus.pcm_data), 64'd0);
    chk({tag, "_pcm_chan"}, 64'(bus.pcm_chan), 64'd0);
    chk({tag, "_pcm_valid"}, 64'(bus.pcm_valid), 64'd0);
    chk({tag, "_frame_err"}, 64'(bus.frame_err), 64'd0);
  endtask

  initial begin
    bus.sck = 1'b0;
    bus.ws  = 1'b0;
    bus.sd  = 1'b0;
    rst     = 1'b1;
    en      = 1'b0;
    m_word  = '0;
    m_last  = '0;
    m_prev  = 1'b0;
    m_chan  = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst = 1'b0;
    @(negedge clk);
    en = 1'b1;

    // Clk/SCK ratio 20: partial first slot, then fixed-pattern frames.
    half = 10;
    send_slot(1'b1, '0, 15);
    for (int f = 0; f < 3; f++) begin
      send_slot(1'b0, 24'h800001, SW);
      send_slot(1'b1, 24'h7FFFFE, SW);
    end
    gap();
    check_events("fixed");

    // Clk/SCK ratio 4 from here on.
    half = 2;
    for (int f = 0; f < 4; f++) begin
      send_slot(1'b0, DW'($urandom), SW);
      send_slot(1'b1, DW'($urandom), SW);
    end
    gap();
    check_events("random");

    // Short slot: WS flips after 10 data bits.
    send_slot(1'b0, DW'($urandom), 11);
    send_slot(1'b1, DW'($urandom), SW);
    send_slot(1'b0, DW'($urandom), SW);
    gap();
    check_events("short");

    // WS held for 40 rises after the edge, then recovery.
    send_slot(1'b1, DW'($urandom), 41);
    send_slot(1'b0, DW'($urandom), SW);
    send_slot(1'b1, DW'($urandom), SW);
    gap();
    check_events("long");

    // Reset at bit 12 of a left slot.
    send_slot(1'b0, DW'($urandom), 13);
    gap();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    m_last = '0;
    check_zero("midreset");
    send_slot(1'b0, DW'($urandom), 19);
    send_slot(1'b1, DW'($urandom), SW);
    send_slot(1'b0, DW'($urandom), SW);
    gap();
    check_events("after_reset");

    // Enable dropped mid-slot: data retained, resync required.
    send_slot(1'b1, DW'($urandom), 10);
    gap();
    en = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("en_drop_hold", 64'(bus.pcm_data), 64'(m_last));
    en = 1'b1;
    @(negedge clk);
    send_slot(1'b1, DW'($urandom), 20);
    send_slot(1'b0, DW'($urandom), SW);
    send_slot(1'b1, DW'($urandom), SW);
    gap();
    check_events("en_drop");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/i2s_mic_rx.md
I2S_MIC_RX -- requirements
Module: i2s_mic_rx

Interface
REQ-001 SHALL have parameter DATA_W, default 24, meaning data bits captured per slot, MSB first.
REQ-002 SHALL have parameter SLOT_W, default 32, meaning SCK periods per WS half-frame; legal range DATA_W..64.
REQ-003 SHALL have port clk, input, 1 bit: sole system clock (60 MHz); clk frequency >= 4x SCK frequency.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-005 SHALL have port en, input, 1 bit: receive enable, synchronous to clk.
REQ-006 SHALL have port mic_sck, input, 1 bit: I2S bit clock driven to the microphones, asynchronous to clk.
REQ-007 SHALL have port mic_ws, input, 1 bit: I2S word select (clk_WS), asynchronous; 0 = left, 1 = right.
REQ-008 SHALL have port mic_sd, input, 1 bit: serial data from the microphone pair, asynchronous.
REQ-009 SHALL have port pcm_data, output, DATA_W bits: last captured sample, two's complement as received.
REQ-010 SHALL have port pcm_chan, output, 1 bit: channel of pcm_data (WS value of its slot).
REQ-011 SHALL have port pcm_valid, output, 1 bit: one-clk pulse marking new pcm_data/pcm_chan.
REQ-012 SHALL have port frame_err, output, 1 bit: one-clk pulse on a malformed slot.

Function
REQ-013 SHALL pass mic_sck, mic_ws, mic_sd through 2-flop synchronizers; SCK rise = synchronized sck 1 while previous synchronized value 0.
REQ-014 SHALL sample synchronized ws and sd only in the clk cycle of an SCK rise.
REQ-015 SHALL implement states IDLE, SYNC, RUN.
REQ-016 IDLE: entered on reset or en=0; leaves to SYNC when en=1.
REQ-017 SYNC: ignores sd; on the first SCK rise where sampled ws differs from previously sampled ws, goes to RUN with bit_cnt=0 and chan=new ws.
REQ-018 RUN, WS-change SCK rise: that rise carries the previous slot's LSB (I2S one-bit delay); SHALL not shift, SHALL reload bit_cnt=0 and chan=new ws.
REQ-019 RUN, other SCK rise with bit_cnt < DATA_W: shift sd into LSB of shift register, increment bit_cnt.
REQ-020 On the rise shifting bit DATA_W-1, pcm_data <= completed word, pcm_chan <= chan, pcm_valid pulses in the same registered update.
REQ-021 Latency: pcm_valid high 3 clk cycles after the clk edge that first registers raw mic_sck=1 for the last data bit.
REQ-022 Rises with DATA_W <= bit_cnt < SLOT_W: sd ignored, bit_cnt increments.
REQ-023 bit_cnt saturates at SLOT_W; a further rise without WS change SHALL pulse frame_err and return to SYNC.
REQ-024 WS change while bit_cnt < DATA_W (short slot, excluding the first slot after SYNC): frame_err pulse, partial word discarded, no pcm_valid, new slot started normally.
REQ-025 frame_err and pcm_valid SHALL never assert in the same cycle; pcm_data holds its value between pulses.
REQ-026 en falling mid-slot: next cycle IDLE, partial word discarded, no pulse; pcm_data retained.
REQ-027 bit_cnt width SHALL be clog2(SLOT_W+1); no wrap permitted.

Reset
REQ-028 rst=1 at a clk edge: state IDLE, synchronizers 0, bit_cnt 0, shift register 0, pcm_data 0, pcm_chan 0, pcm_valid 0, frame_err 0.
REQ-029 Reset mid-slot SHALL discard the partial word and require a fresh WS edge (SYNC) before any pcm_valid.

Structure
REQ-030 Package i2s_mic_pkg SHALL hold DATA_W/SLOT_W defaults and the IDLE/SYNC/RUN state encoding.
REQ-031 Sub-module sync_edge_det (2-flop sync plus rising-edge pulse) SHALL be instantiated for mic_sck; ws and sd use plain 2-flop syncs.

Verification
REQ-032 en=1, SCK 3 MHz, 64-SCK frames, left=24'h800001, right=24'h7FFFFE -> pcm_valid pulses alternating chan 0/1 with exact values, frame_err 0.
REQ-033 First partial frame after en rise -> no pcm_valid until after the first WS edge, then correct data.
REQ-034 WS toggles after 10 bits in a slot -> frame_err one pulse, no pcm_valid for that slot, next slot correct.
REQ-035 WS held constant for 40 SCK rises in RUN -> frame_err on rise 33, state SYNC, recovery on next WS edge.
REQ-036 rst asserted at bit 12 of a left slot -> outputs 0 next cycle; first subsequent pcm_valid follows a full slot after a WS edge.
REQ-037 Latency check: pcm_valid exactly 3 clk after raw SCK rise of bit 23, 1 clk wide, for clk/SCK ratios 4 and 20.
